// File: rtl/alu_1.sv
// Clocked ALU: one result register loads f(p, a, b) every rising edge.
// Asynchronous active-high reset clears the result immediately.
module alu_1 #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       p,
  output logic [WIDTH-1:0] c
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] c_q;

  // Next result; all arithmetic is unsigned and truncated to WIDTH bits.
  always_comb begin
    c_d = '0;
    case (p)
      OP_ADD:  c_d = WIDTH'(a + b);
      OP_SUB:  c_d = WIDTH'(a - b);
      OP_AND:  c_d = a & b;
      OP_OR:   c_d = a | b;
      OP_XOR:  c_d = a ^ b;
      OP_MUL:  c_d = WIDTH'(a * b);
      OP_SHL:  c_d = WIDTH'(a << 1);
      OP_SHR:  c_d = WIDTH'(a >> 1);
      default: c_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_q <= '0;
    else     c_q <= c_d;
  end

  assign c = c_q;

endmodule

// File: tb/tb_alu_1.sv
// Directed bench for alu_1 (WIDTH=2) with hand-computed expected results.
module tb_alu_1;

  logic       clk;
  logic       rst;
  logic [1:0] a;
  logic [1:0] b;
  logic [2:0] p;
  logic [1:0] c;

  int vectors;
  int miscompares;

  alu_1 #(.WIDTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .p  (p),
    .c  (c)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] exp);
    vectors++;
    assert (c === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, c, exp);
    end
  endtask

  // Apply inputs at the falling edge, confirm c holds, then check after the rising edge.
  task automatic apply(input string tag, input logic [2:0] op, input logic [1:0] av,
                       input logic [1:0] bv, input logic [1:0] exp);
    logic [1:0] prev;
    @(negedge clk);
    prev = c;
    a = av;
    b = bv;
    p = op;
    #1 check({tag, "_hold"}, prev);
    @(posedge clk);
    #1 check(tag, exp);
  endtask

  logic [1:0] sweep_exp [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    sweep_exp   = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01};
    rst <= 1'b1;
    a   = 2'b00;
    b   = 2'b00;
    p   = 3'b000;

    // Reset held for 100 ns: c stays 0 even with active operands.
    #1 check("rst_t0", 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check($sformatf("rst_hold%0d", i), 2'b00);
      if (i == 2) begin
        a = 2'b11;
        b = 2'b11;
      end
    end

    // Release, load a value, then pulse reset between edges.
    @(negedge clk);
    rst <= 1'b0;
    a = 2'b11;
    b = 2'b11;
    p = 3'b000;
    @(posedge clk);
    #1 check("post_rst_add", 2'b10);
    #4 rst <= 1'b1;
    #1 check("async_pulse", 2'b00);
    @(negedge clk);
    rst <= 1'b0;
    a = 2'b00;
    b = 2'b00;
    @(posedge clk);
    #1 check("after_pulse", 2'b00);

    // Opcode sweep with a=10, b=01, each held five cycles; async reset mid-sweep at SUB.
    for (int op = 0; op < 8; op++) begin
      apply($sformatf("sweep_p%0d", op), 3'(op), 2'b10, 2'b01, sweep_exp[op]);
      repeat (4) begin
        @(posedge clk);
        #1 check($sformatf("sweep_p%0d_stable", op), sweep_exp[op]);
      end
      if (op == 1) begin
        #3 rst <= 1'b1;
        #1 check("midstream_rst", 2'b00);
        @(negedge clk);
        rst <= 1'b0;
        @(posedge clk);
        #1 check("midstream_recover", sweep_exp[op]);
      end
    end

    // Wrap-around.
    apply("add_wrap", 3'b000, 2'b11, 2'b01, 2'b00);
    apply("sub_wrap", 3'b001, 2'b01, 2'b10, 2'b11);
    apply("mul_wrap", 3'b101, 2'b11, 2'b11, 2'b01);

    // Shifts ignore b.
    apply("shl_b00", 3'b110, 2'b11, 2'b00, 2'b10);
    apply("shr_b00", 3'b111, 2'b11, 2'b00, 2'b01);
    apply("shl_b11", 3'b110, 2'b11, 2'b11, 2'b10);
    apply("shr_b11", 3'b111, 2'b11, 2'b11, 2'b01);

    // All three inputs change together.
    apply("all_change", 3'b100, 2'b01, 2'b11, 2'b10);

    // Reset released on a rising edge: that edge must not load.
    @(negedge clk);
    rst <= 1'b1;
    a = 2'b01;
    b = 2'b01;
    p = 3'b000;
    #1 check("edge_rel_assert", 2'b00);
    @(posedge clk);
    rst <= 1'b0;
    #1 check("edge_rel_noload", 2'b00);
    @(posedge clk);
    #1 check("edge_rel_load", 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
